// File: rtl/router_port_rx.sv
// Receive deframer: parses the dst/src/length header, buffers payload in a FIFO, raises Q_BP near full.
// Define ROUTER_PORT_RX_STATS_EN to add the saturating FRAME_CNT / ERR_CNT outputs.
module router_port_rx #(
  parameter int DEPTH     = 16,
  parameter int BP_MARGIN = 4,
  parameter int MAX_LEN   = 1024
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] Q,
  input  logic        Q_VALID,
  input  logic        Q_SOF,
  output logic        Q_BP,
  output logic [55:0] HDR_DST,
  output logic [55:0] HDR_SRC,
  output logic [15:0] HDR_LEN,
  output logic        HDR_VALID,
  output logic [63:0] P_DATA,
  output logic        P_VALID,
  output logic        P_LAST,
  output logic        P_ERR,
  input  logic        P_READY,
  output logic        ERR,
`ifdef ROUTER_PORT_RX_STATS_EN
  output logic [31:0] FRAME_CNT,
  output logic [31:0] ERR_CNT,
`endif
  output logic [2:0]  ERR_CODE
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] L_MARGIN = CW'(BP_MARGIN);
  localparam logic [15:0]   L_MAX    = 16'(MAX_LEN);
  localparam logic [7:0]    TAG      = 8'h01;

  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_LEN, S_PAY, S_DROP} state_t;

  state_t        r_state, w_nxt;
  logic [63:0]   r_q;
  logic          r_qv, r_qsof;
  logic [15:0]   r_len, r_cnt;
  logic          r_ferr, r_bp;
  logic [65:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_fcnt;

  logic          w_tag_ok, w_rd, w_full, w_wr;
  logic [65:0]   w_wdata, w_head;
  logic          w_hdr_vld, w_err, w_ld_dst, w_ld_src, w_ld_len, w_dec, w_set_ferr;
  logic [2:0]    w_code;

  // Input stage: all parsing works on the registered word
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_qv   <= 1'b0;
      r_qsof <= 1'b0;
    end else begin
      r_qv   <= Q_VALID;
      r_qsof <= Q_SOF;
    end
  end

  always_ff @(posedge CLK) r_q <= Q;

  assign w_tag_ok = (r_q[63:56] == TAG);
  assign w_rd     = P_VALID && P_READY;
  // A slot being read this cycle can be refilled in the same cycle
  assign w_full   = (r_fcnt == L_DEPTH) && !w_rd;

  always_comb begin
    w_nxt      = r_state;
    w_hdr_vld  = 1'b0;
    w_err      = 1'b0;
    w_code     = 3'd0;
    w_wr       = 1'b0;
    w_wdata    = '0;
    w_ld_dst   = 1'b0;
    w_ld_src   = 1'b0;
    w_ld_len   = 1'b0;
    w_dec      = 1'b0;
    w_set_ferr = 1'b0;
    if (r_qv) begin
      if (r_qsof) begin
        if (r_state == S_HDR1 || r_state == S_LEN || r_state == S_PAY) begin
          w_err  = 1'b1;
          w_code = 3'd3;
        end
        if (r_state == S_PAY && !w_full) begin
          w_wr    = 1'b1;
          w_wdata = {1'b1, 1'b1, 64'd0};
        end
        if (w_tag_ok) begin
          w_ld_dst = 1'b1;
          w_nxt    = S_HDR1;
        end else begin
          w_nxt = S_IDLE;
          if (!w_err) begin
            w_err  = 1'b1;
            w_code = 3'd1;
          end
        end
      end else begin
        case (r_state)
          S_HDR1: begin
            if (w_tag_ok) begin
              w_ld_src = 1'b1;
              w_nxt    = S_LEN;
            end else begin
              w_err  = 1'b1;
              w_code = 3'd1;
              w_nxt  = S_DROP;
            end
          end
          S_LEN: begin
            if (r_q[15:0] > L_MAX) begin
              w_err  = 1'b1;
              w_code = 3'd2;
              w_nxt  = S_DROP;
            end else begin
              w_hdr_vld = 1'b1;
              w_ld_len  = 1'b1;
              w_nxt     = (r_q[15:0] == 16'd0) ? S_IDLE : S_PAY;
            end
          end
          S_PAY: begin
            w_dec = 1'b1;
            if (r_cnt == 16'd1) w_nxt = S_IDLE;
            if (w_full) begin
              w_err      = 1'b1;
              w_code     = 3'd4;
              w_set_ferr = 1'b1;
            end else begin
              w_wr    = 1'b1;
              w_wdata = {r_ferr, (r_cnt == 16'd1), r_q};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Parser state, header fields and FIFO control
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      HDR_DST <= '0;
      HDR_SRC <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_ferr  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_fcnt  <= '0;
      r_bp    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_ld_dst) HDR_DST <= r_q[55:0];
      if (w_ld_src) HDR_SRC <= r_q[55:0];
      if (w_ld_len) begin
        r_len  <= r_q[15:0];
        r_cnt  <= r_q[15:0];
        r_ferr <= 1'b0;
      end else begin
        if (w_dec) r_cnt <= r_cnt - 16'd1;
        if (w_set_ferr) r_ferr <= 1'b1;
      end
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: ;
      endcase
      r_bp <= (L_DEPTH - r_fcnt) <= L_MARGIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wp] <= w_wdata;
  end

  assign w_head    = r_mem[r_rp];
  assign P_VALID   = (r_fcnt != '0);
  assign P_DATA    = P_VALID ? w_head[63:0] : 64'd0;
  assign P_LAST    = P_VALID && w_head[64];
  assign P_ERR     = P_VALID && w_head[65];
  assign Q_BP      = r_bp;
  assign HDR_VALID = w_hdr_vld;
  assign HDR_LEN   = w_hdr_vld ? r_q[15:0] : r_len;
  assign ERR       = w_err;
  assign ERR_CODE  = w_code;

`ifdef ROUTER_PORT_RX_STATS_EN
  logic        w_frame_done;
  logic [31:0] r_frame_cnt, r_err_cnt;

  // A clean last entry (terminators always carry err) or an accepted zero-length header
  assign w_frame_done = (w_wr && w_wdata[64] && !w_wdata[65]) ||
                        (w_hdr_vld && r_q[15:0] == 16'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_frame_done && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign FRAME_CNT = r_frame_cnt;
  assign ERR_CNT   = r_err_cnt;
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: directed and randomized frames against a queue-based expectation model.
module tb_router_port_rx;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [63:0] Q;
  logic        Q_VALID, Q_SOF, Q_BP;
  logic [55:0] HDR_DST, HDR_SRC;
  logic [15:0] HDR_LEN;
  logic        HDR_VALID;
  logic [63:0] P_DATA;
  logic        P_VALID, P_LAST, P_ERR, P_READY, ERR;
  logic [2:0]  ERR_CODE;
`ifdef ROUTER_PORT_RX_STATS_EN
  logic [31:0] FRAME_CNT, ERR_CNT;
  logic [31:0] fc0;
`endif

  router_port_rx dut (
    .CLK(CLK), .RST_N(RST_N), .Q(Q), .Q_VALID(Q_VALID), .Q_SOF(Q_SOF), .Q_BP(Q_BP),
    .HDR_DST(HDR_DST), .HDR_SRC(HDR_SRC), .HDR_LEN(HDR_LEN), .HDR_VALID(HDR_VALID),
    .P_DATA(P_DATA), .P_VALID(P_VALID), .P_LAST(P_LAST), .P_ERR(P_ERR), .P_READY(P_READY),
    .ERR(ERR),
`ifdef ROUTER_PORT_RX_STATS_EN
    .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT),
`endif
    .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [55:0] dst; logic [55:0] src; logic [15:0] len;} hdr_t;
  typedef struct packed {logic [63:0] d; logic l; logic e;} ent_t;

  hdr_t       hdr_q[$];
  ent_t       exp_q[$];
  logic [2:0] err_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         rnd_rdy = 0;
  bit         rnd_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic step(input logic [63:0] d, input logic v, input logic s);
    Q = d; Q_VALID = v; Q_SOF = s;
    if (rnd_rdy) P_READY = ($urandom_range(0, 3) != 0);
    @(posedge CLK);
    #1;
    Q_VALID = 1'b0; Q_SOF = 1'b0;
  endtask

  // Router side: optionally honours Q_BP and inserts random idle cycles
  task automatic send_word(input logic [63:0] d, input logic s, input bit honor);
    int g = 0;
    while (honor && (Q_BP || (rnd_stall && $urandom_range(0, 3) == 0)) && g < 200) begin
      step(64'd0, 1'b0, 1'b0);
      g++;
    end
    if (g >= 200) chk("bp_wait_timeout", 64'(Q_BP), 64'd0);
    step(d, 1'b1, s);
  endtask

  task automatic push_ent(input logic [63:0] d, input logic l, input logic e);
    ent_t x;
    x.d = d; x.l = l; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic push_hdr(input logic [55:0] dst, input logic [55:0] src, input logic [15:0] len);
    hdr_t h;
    h.dst = dst; h.src = src; h.len = len;
    hdr_q.push_back(h);
  endtask

  task automatic send_frame(input logic [55:0] dst, input logic [55:0] src, input int len,
                            input bit honor);
    logic [63:0] r, d;
    push_hdr(dst, src, 16'(len));
    send_word({8'h01, dst}, 1'b1, honor);
    send_word({8'h01, src}, 1'b0, honor);
    r = rand64();
    send_word({r[63:16], 16'(len)}, 1'b0, honor);
    for (int i = 0; i < len; i++) begin
      d = rand64();
      push_ent(d, i == len - 1, 1'b0);
      send_word(d, 1'b0, honor);
    end
  endtask

  task automatic drain();
    int g = 0;
    rnd_rdy = 0; rnd_stall = 0; P_READY = 1'b1;
    while ((exp_q.size() > 0 || hdr_q.size() > 0 || err_q.size() > 0) && g < 400) begin
      step(64'd0, 1'b0, 1'b0);
      g++;
    end
    step(64'd0, 1'b0, 1'b0);
    chk("drain_payload", 64'(exp_q.size()), 64'd0);
    chk("drain_hdr", 64'(hdr_q.size()), 64'd0);
    chk("drain_err", 64'(err_q.size()), 64'd0);
    chk("drain_fifo_empty", 64'(P_VALID), 64'd0);
  endtask

  // Output monitor: every header, error and payload transfer must match the model queues
  hdr_t       mh;
  ent_t       me;
  logic [2:0] mc;
  always @(negedge CLK) begin
    if (RST_N) begin
      if (HDR_VALID) begin
        chk("hdr_expected", 64'(hdr_q.size() > 0), 64'd1);
        if (hdr_q.size() > 0) begin
          mh = hdr_q.pop_front();
          chk("hdr_dst", 64'(HDR_DST), 64'(mh.dst));
          chk("hdr_src", 64'(HDR_SRC), 64'(mh.src));
          chk("hdr_len", 64'(HDR_LEN), 64'(mh.len));
        end
      end
      if (ERR) begin
        chk("err_expected", 64'(err_q.size() > 0), 64'd1);
        if (err_q.size() > 0) begin
          mc = err_q.pop_front();
          chk("err_code", 64'(ERR_CODE), 64'(mc));
        end
      end
      if (P_VALID && P_READY) begin
        chk("pay_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          me = exp_q.pop_front();
          chk("pay_data", P_DATA, me.d);
          chk("pay_last", 64'(P_LAST), 64'(me.l));
          chk("pay_err", 64'(P_ERR), 64'(me.e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent, bp_at, stalls;
    logic [63:0] d;

    RST_N = 1'b0; Q = '0; Q_VALID = 1'b0; Q_SOF = 1'b0; P_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q_bp", 64'(Q_BP), 64'd0);
    chk("rst_hdr_valid", 64'(HDR_VALID), 64'd0);
    chk("rst_hdr_dst", 64'(HDR_DST), 64'd0);
    chk("rst_hdr_len", 64'(HDR_LEN), 64'd0);
    chk("rst_p_valid", 64'(P_VALID), 64'd0);
    chk("rst_p_last_err", 64'({P_LAST, P_ERR}), 64'd0);
    chk("rst_err", 64'({ERR, ERR_CODE}), 64'd0);
    RST_N = 1'b1;
    P_READY = 1'b1;
    step(64'd0, 1'b0, 1'b0);

    // Good frame with latency checks
    push_hdr(56'd1, 56'd2, 16'd10);
    send_word({8'h01, 56'd1}, 1'b1, 1'b0);
    send_word({8'h01, 56'd2}, 1'b0, 1'b0);
    send_word(64'd10, 1'b0, 1'b0);
    chk("hdr_valid_latency", 64'(HDR_VALID), 64'd1);
    chk("hdr_len_at_pulse", 64'(HDR_LEN), 64'd10);
    for (int i = 1; i <= 10; i++) begin
      push_ent(64'(i), i == 10, 1'b0);
      send_word(64'(i), 1'b0, 1'b0);
      if (i == 1) chk("pay_latency_t1", 64'(P_VALID), 64'd0);
      if (i == 2) begin
        chk("pay_latency_t2", 64'(P_VALID), 64'd1);
        chk("pay_latency_data", P_DATA, 64'd1);
      end
    end
    drain();

    // Truncation by SOF after 3 of 10 words
    push_hdr(56'd3, 56'd4, 16'd10);
    send_word({8'h01, 56'd3}, 1'b1, 1'b0);
    send_word({8'h01, 56'd4}, 1'b0, 1'b0);
    send_word(64'd10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = rand64();
      push_ent(d, 1'b0, 1'b0);
      send_word(d, 1'b0, 1'b0);
    end
    err_q.push_back(3'd3);
    push_ent(64'd0, 1'b1, 1'b1);
    push_hdr(56'd5, 56'd6, 16'd2);
    send_word({8'h01, 56'd5}, 1'b1, 1'b0);
    chk("trunc_err", 64'(ERR), 64'd1);
    chk("trunc_code", 64'(ERR_CODE), 64'd3);
    send_word({8'h01, 56'd6}, 1'b0, 1'b0);
    send_word(64'd2, 1'b0, 1'b0);
    push_ent(64'hA1, 1'b0, 1'b0);
    send_word(64'hA1, 1'b0, 1'b0);
    push_ent(64'hA2, 1'b1, 1'b0);
    send_word(64'hA2, 1'b0, 1'b0);
    drain();

    // Bad tag on word1: frame dropped until the next SOF
    send_word({8'h01, 56'd7}, 1'b1, 1'b0);
    err_q.push_back(3'd1);
    send_word({8'h02, 56'd8}, 1'b0, 1'b0);
    chk("badtag_err", 64'(ERR), 64'd1);
    chk("badtag_code", 64'(ERR_CODE), 64'd1);
    send_word(64'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(rand64(), 1'b0, 1'b0);
    send_frame(56'h77, 56'h88, 3, 1'b0);
    drain();

    // Oversized length: frame dropped
    send_word({8'h01, 56'd20}, 1'b1, 1'b0);
    send_word({8'h01, 56'd21}, 1'b0, 1'b0);
    err_q.push_back(3'd2);
    send_word(64'd2000, 1'b0, 1'b0);
    chk("toolong_code", 64'({ERR, ERR_CODE}), 64'({1'b1, 3'd2}));
    for (int i = 0; i < 4; i++) send_word(rand64(), 1'b0, 1'b0);
    send_frame(56'h99, 56'hAA, 2, 1'b0);
    drain();

    // Zero-length frame
`ifdef ROUTER_PORT_RX_STATS_EN
    fc0 = FRAME_CNT;
`endif
    send_frame(56'd9, 56'd10, 0, 1'b0);
    repeat (3) step(64'd0, 1'b0, 1'b0);
    chk("zero_len_no_payload", 64'(P_VALID), 64'd0);
`ifdef ROUTER_PORT_RX_STATS_EN
    chk("zero_len_frame_cnt", 64'(FRAME_CNT), 64'(fc0 + 32'd1));
`endif
    drain();

    // Backpressure: endpoint stalled, router honours Q_BP
    P_READY = 1'b0;
    push_hdr(56'd11, 56'd12, 16'd20);
    send_word({8'h01, 56'd11}, 1'b1, 1'b1);
    send_word({8'h01, 56'd12}, 1'b0, 1'b1);
    send_word(64'd20, 1'b0, 1'b1);
    sent = 0; bp_at = -1; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      int g = 0;
      while (Q_BP && g < 100) begin
        if (bp_at < 0) bp_at = sent;
        step(64'd0, 1'b0, 1'b0);
        g++;
        stalls++;
        if (stalls == 4) P_READY = 1'b1;
      end
      push_ent(64'(100 + i), i == 19, 1'b0);
      step(64'(100 + i), 1'b1, 1'b0);
      sent++;
    end
    chk("bp_rise_after_words", 64'(bp_at), 64'd14);
    drain();

    // Randomized frames with random stalls and endpoint readiness
    rnd_rdy = 1; rnd_stall = 1;
    for (int f = 0; f < 8; f++) begin
      logic [63:0] a, b;
      a = rand64(); b = rand64();
      send_frame(a[55:0], b[55:0], int'($urandom_range(0, 24)), 1'b1);
    end
    drain();

    // Reset mid-payload with the FIFO half full
    P_READY = 1'b0;
    push_hdr(56'd13, 56'd14, 16'd16);
    send_word({8'h01, 56'd13}, 1'b1, 1'b0);
    send_word({8'h01, 56'd14}, 1'b0, 1'b0);
    send_word(64'd16, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_word(rand64(), 1'b0, 1'b0);
    repeat (2) step(64'd0, 1'b0, 1'b0);
    chk("rst_pre_fifo_filled", 64'(P_VALID), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_p_valid", 64'(P_VALID), 64'd0);
    chk("rst_mid_p_last_err", 64'({P_LAST, P_ERR}), 64'd0);
    chk("rst_mid_hdr_dst", 64'(HDR_DST), 64'd0);
    chk("rst_mid_hdr_src", 64'(HDR_SRC), 64'd0);
    chk("rst_mid_hdr_len", 64'(HDR_LEN), 64'd0);
    chk("rst_mid_q_bp", 64'(Q_BP), 64'd0);
    chk("rst_mid_err", 64'({ERR, ERR_CODE, HDR_VALID}), 64'd0);
    exp_q.delete();
    err_q.delete();
    hdr_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    P_READY = 1'b1;
    step(64'd0, 1'b0, 1'b0);
    chk("rst_post_no_payload", 64'(P_VALID), 64'd0);
    send_frame(56'd15, 56'd16, 5, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_port_rx.md
# router_port_rx

Receive-side deframer for one router_core output port. Accepts the 64-bit word stream `Q`/`Q_VALID`/`Q_SOF` and parses the three-word header: destination, source and payload length. Buffers payload words in a local FIFO and drives `Q_BP` back into router_core so the FIFO never overflows. Presents header fields and payload to the local endpoint over a valid/ready handshake.

## Interface
- DEPTH, 16: payload FIFO entries; power of two, at least 8.
- BP_MARGIN, 4: `Q_BP` asserts when free entries <= BP_MARGIN; covers the router's backpressure reaction latency plus one reserved terminator slot.
- MAX_LEN, 1024: largest accepted payload length in words.

Ports:
- CLK, in, 1: clock, rising edge.
- RST_N, in, 1: asynchronous, active-low reset.
- Q, in, 64: frame word from router_core.
- Q_VALID, in, 1: `Q` is valid this cycle.
- Q_SOF, in, 1: `Q` is header word 0 (start of frame); qualified by `Q_VALID`.
- Q_BP, out, 1: backpressure to router_core.
- HDR_DST, out, 56: destination field of the current frame.
- HDR_SRC, out, 56: source field of the current frame.
- HDR_LEN, out, 16: payload length of the current frame.
- HDR_VALID, out, 1: one-cycle pulse; header fields are valid.
- P_DATA, out, 64: payload word.
- P_VALID, out, 1: payload word available.
- P_LAST, out, 1: last payload word of the frame.
- P_ERR, out, 1: frame ended abnormally; qualified with `P_LAST`.
- P_READY, in, 1: endpoint accepts `P_DATA`.
- ERR, out, 1: one-cycle error pulse.
- ERR_CODE, out, 3: 1 = bad tag, 2 = length > MAX_LEN, 3 = truncated by SOF, 4 = overflow.

## Operation
- Frame format:
  - word0 = {8'h01, dst[55:0]} with `Q_SOF` = 1.
  - word1 = {8'h01, src[55:0]}.
  - word2 = length L; bits [15:0] used, bits [63:16] ignored.
  - L payload words follow.
- A cycle with `Q_VALID` = 0 is a stall, never an error.
- Input stage registers `Q`/`Q_VALID`/`Q_SOF`. All parsing acts on the registered word.
- FSM states: IDLE, HDR1, LEN, PAY, DROP.
  - IDLE: a SOF word with tag 8'h01 latches dst -> HDR1. Bad tag -> ERR code 1, stay in IDLE. Non-SOF words are discarded silently.
  - HDR1: tag 8'h01 -> latch src -> LEN. Bad tag -> ERR code 1 -> DROP.
  - LEN:
    - L > MAX_LEN -> ERR code 2 -> DROP.
    - Otherwise pulse HDR_VALID.
    - L = 0 -> IDLE; nothing is written to the FIFO.
    - L > 0 -> PAY with remaining-count = L.
  - PAY: each valid word is written {data, last = (count == 1), err = frame_err}; count decrements. The write with count == 1 -> IDLE.
  - DROP: discards words until the next SOF, which is processed as IDLE would process it.
- SOF in HDR1, LEN, PAY or DROP: reparse it as word0.
  - In HDR1, LEN or PAY: ERR code 3.
  - In PAY only: also write a terminator entry {data 0, last 1, err 1} into the reserved slot.
- Overflow:
  - A PAY word arriving with the FIFO full is dropped, with ERR code 4.
  - frame_err is set, so that frame's `P_LAST` entry carries `P_ERR` = 1.
  - The count still decrements.
- Payload handshake: a transfer occurs when `P_VALID` && `P_READY`. `P_DATA`/`P_LAST`/`P_ERR` are held stable while `P_VALID` && !`P_READY`.
- FIFO read and write in the same cycle are both allowed, including when the FIFO is full or empty.

## Timing
- Reset values: `Q_BP` 0, HDR_* 0, `HDR_VALID` 0, `P_VALID` 0, `P_LAST` 0, `P_ERR` 0, `ERR` 0, `ERR_CODE` 0. FSM resets to IDLE, FIFO to empty, counters to 0.
- `HDR_VALID` pulses 1 cycle after word2 is on `Q`.
- A payload word on `Q` at cycle t appears on `P_DATA` at t+2, provided the FIFO was empty and the endpoint is ready.
- `Q_BP` is registered and updates 1 cycle after the FIFO occupancy change.
- `ERR` pulses 1 cycle after the offending word is on `Q`.
- Reset asserted mid-frame: all state clears immediately. No terminator is generated.

## Configuration
- ROUTER_PORT_RX_STATS_EN defined: adds outputs
  - FRAME_CNT (32): frames that ended in PAY with a good `P_LAST`, or with L = 0.
  - ERR_CNT (32): `ERR` pulses.
  - Both counters saturate at all-ones and reset to 0.
- ROUTER_PORT_RX_STATS_EN undefined: these ports and registers do not exist.

## Test plan
- Good frame: words {01,1}, {01,2}, 10, then payload 1..10, `P_READY` = 1. Required: `HDR_VALID` with DST 1, SRC 2, LEN 10; `P_DATA` 1..10; `P_LAST` on word 10; `P_ERR` 0.
- Truncation: SOF arrives after 3 of 10 payload words. Required: ERR code 3; 3 data entries followed by a terminator with last = 1 and err = 1; the new frame parses normally.
- Backpressure: `P_READY` = 0 with a 20-word payload and the router honouring `Q_BP`. Required: `Q_BP` rises once occupancy reaches 12 (DEPTH 16); no overflow; all 20 words are delivered after `P_READY` = 1.
- Header faults:
  - Word1 tag 8'h02 -> ERR code 1; the frame is dropped.
  - L = 2000 -> ERR code 2; the frame is dropped.
- Zero-length frame: L = 0. Required: `HDR_VALID` with LEN 0; `P_VALID` stays 0. With ROUTER_PORT_RX_STATS_EN defined, FRAME_CNT increments.
- Reset: assert `RST_N` = 0 mid-payload with the FIFO half full. Required: all outputs return to their reset values immediately; the next frame parses cleanly.
